serial_subtractor: RTL and testbench

- Multi-cycle, bit-serial subtractor. It computes D = A - B - b_in over WIDTH clock cycles, one bit per cycle, LSB first.
- Operates in the inverse direction of the team's ripple-carry adder blocks: borrow propagation in place of carry propagation.
- Intended for area-limited datapaths where a start/done handshake replaces a combinational subtract.

---
 rtl/serial_subtractor.sv | 128 ++++++++++++
 tb/tb_serial_subtractor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial subtractor, D = A - B - b_in, LSB first over WIDTH
//               cycles with a start/done handshake. Optional signed overflow
//               flag port ovf when SERIAL_SUB_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             b_out,
    output logic             zero
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_res;
    logic               r_borrow;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_a_bit;
    logic               w_b_bit;
    logic               w_diff;
    logic               w_borrow_nxt;
    logic               w_last;
    logic [WIDTH-1:0]   w_result;

    assign w_a_bit      = r_a_sh[0];
    assign w_b_bit      = r_b_sh[0];
    assign w_diff       = w_a_bit ^ w_b_bit ^ r_borrow;
    assign w_borrow_nxt = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_borrow);
    assign w_last       = (r_cnt == c_LAST);
    // Result bits enter from the MSB so bit 0 lands in place after WIDTH shifts.
    assign w_result     = {w_diff, r_res[WIDTH-1:1]};

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            d        <= '0;
            b_out    <= 1'b0;
            zero     <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_borrow <= b_in;
                        r_res    <= '0;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res    <= w_result;
                    r_borrow <= w_borrow_nxt;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        d     <= w_result;
                        b_out <= w_borrow_nxt;
                        zero  <= (w_result == '0);
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit the operand LSBs are the latched MSBs.
                        ovf   <= (w_a_bit != w_b_bit) && (w_diff != w_a_bit);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Scoreboard bench for serial_subtractor (WIDTH = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         b_out;
    logic         zero;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         b_out;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    serial_subtractor #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .b_out (b_out),
        .zero  (zero)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every done must match the oldest pending result.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("done_expected", 32'd0, 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("d", 32'(d), 32'(e.d));
                check("b_out", 32'(b_out), 32'(e.b_out));
                check("zero", 32'(zero), 32'(e.zero));
`ifdef SERIAL_SUB_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Called at a negedge; returns one negedge later with start deasserted.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ibin, input bit push);
        logic [W:0] full;
        exp_t       e;
        a     = ia;
        b     = ib;
        b_in  = ibin;
        start = 1'b1;
        if (push) begin
            full    = {1'b0, ia} - {1'b0, ib} - {{W{1'b0}}, ibin};
            e.d     = full[W-1:0];
            e.b_out = full[W];
            e.zero  = (full[W-1:0] == '0);
            e.ovf   = (ia[W-1] != ib[W-1]) && (full[W-1] != ia[W-1]);
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Observes the cycles following an accepted start; optionally scrambles inputs.
    task automatic measure(input bit scramble, input string tag);
        int busy_cnt = 0;
        int done_cnt = 0;
        int done_at  = 0;
        for (int k = 1; k <= W + 4; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (scramble && k <= W) begin
                a    = W'($urandom);
                b    = W'($urandom);
                b_in = 1'($urandom);
            end
            @(negedge clk);
        end
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_done_at"}, 32'(done_at), 32'(W + 1));
    endtask

    initial begin
        int done_seen;
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        b_in  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_b_out", 32'(b_out), 32'd0);
        check("rst_zero", 32'(zero), 32'd1);

        issue(8'h35, 8'h12, 1'b0, 1'b1); measure(1'b0, "op35_12");
        issue(8'h12, 8'h35, 1'b0, 1'b1); measure(1'b0, "op12_35");
        issue(8'h00, 8'h00, 1'b1, 1'b1); measure(1'b0, "op00_bin");
        issue(8'h5A, 8'h5A, 1'b0, 1'b1); measure(1'b0, "op5A_5A");

        // Starts at RUN cycle 3 and in the DONE cycle must be ignored.
        issue(8'h40, 8'h01, 1'b0, 1'b1);
        for (int k = 1; k <= W + 1; k++) begin
            if (k == 3 || k == W + 1) begin
                a = 8'hFF; b = 8'h00; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ignored_start_idle", 32'(busy), 32'd0);
        issue(8'hFF, 8'h00, 1'b0, 1'b1); measure(1'b0, "opFF_00");

        // Mid-operation reset discards the in-flight result.
        issue(8'h35, 8'h12, 1'b0, 1'b1); measure(1'b0, "pre_reset");
        issue(8'h77, 8'h11, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_d", 32'(d), 32'd0);
        check("mid_rst_zero", 32'(zero), 32'd1);
        check("mid_rst_b_out", 32'(b_out), 32'd0);
        done_seen = 0;
        for (int k = 0; k < W + 4; k++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        check("mid_rst_no_done", 32'(done_seen), 32'd0);
        issue(8'h35, 8'h12, 1'b0, 1'b1); measure(1'b0, "post_reset");

        // Inputs toggling during RUN must not disturb the latched operands.
        issue(8'hA0, 8'h0F, 1'b0, 1'b1); measure(1'b1, "scramble");

        issue(8'h80, 8'h01, 1'b0, 1'b1); measure(1'b0, "op80_01");
        issue(8'h05, 8'h03, 1'b0, 1'b1); measure(1'b0, "op05_03");
        issue(8'hFF, 8'hFF, 1'b1, 1'b1); measure(1'b0, "opFF_FF_bin");
        issue(8'h00, 8'hFF, 1'b0, 1'b1); measure(1'b0, "op00_FF");
        for (int i = 0; i < 6; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
            measure(1'b1, "random");
        end

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
